// File: rtl/ifu_branch_history_table_if.sv
// ---------------------------------------------------------------------------
// ifu_branch_history_table_if
//   Bundles the lookup, training and prediction signals of the IFU branch
//   history table.
//   master : fetch/execute side, drives lookups and resolved-branch feedback
//   slave  : the branch history table itself
//   Signals
//     lookup_valid_in   fetch PC valid this cycle
//     lookup_pc_in      fetch PC (index taken from bits [INDEX_WIDTH+1:2])
//     update_enable_in  resolved branch feedback valid
//     update_indx_in    entry to train
//     update_taken_in   actual branch outcome (1 = taken)
//     ready_out         table initialised
//     pred_valid_out    prediction outputs valid
//     pred_taken_out    predicted direction (counter msb)
//     pred_counter_out  raw 2-bit counter of the looked-up entry
// ---------------------------------------------------------------------------
interface ifu_branch_history_table_if #(
  parameter int INDEX_WIDTH = 10
);
  logic                   lookup_valid_in;
  logic [31:0]            lookup_pc_in;
  logic                   update_enable_in;
  logic [INDEX_WIDTH-1:0] update_indx_in;
  logic                   update_taken_in;
  logic                   ready_out;
  logic                   pred_valid_out;
  logic                   pred_taken_out;
  logic [1:0]             pred_counter_out;

  modport master (
    output lookup_valid_in,
    output lookup_pc_in,
    output update_enable_in,
    output update_indx_in,
    output update_taken_in,
    input  ready_out,
    input  pred_valid_out,
    input  pred_taken_out,
    input  pred_counter_out
  );

  modport slave (
    input  lookup_valid_in,
    input  lookup_pc_in,
    input  update_enable_in,
    input  update_indx_in,
    input  update_taken_in,
    output ready_out,
    output pred_valid_out,
    output pred_taken_out,
    output pred_counter_out
  );
endinterface

// File: rtl/ifu_branch_history_table.sv
// ---------------------------------------------------------------------------
// ifu_branch_history_table
//   Table of 2-bit saturating counters feeding the branch predictor with a
//   taken/not-taken hint. After reset the table walks every entry writing
//   INIT_STATE (one entry per cycle), then raises ready_out and serves
//   lookups (1-cycle latency) and training updates (one per cycle).
//   Ports
//     clock_in  : sole clock, rising edge
//     reset_in  : asynchronous, active-high reset
//     bht_if    : slave modport carrying lookup, update and prediction
//                 signals (see ifu_branch_history_table_if)
// ---------------------------------------------------------------------------
module ifu_branch_history_table #(
  parameter int         INDEX_WIDTH = 10,
  parameter logic [1:0] INIT_STATE  = 2'b01
) (
  input  logic                          clock_in,
  input  logic                          reset_in,
  ifu_branch_history_table_if.slave     bht_if
);

  localparam int                     ENTRIES  = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] PTR_LAST = '1;
  localparam logic [INDEX_WIDTH-1:0] PTR_ONE  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Saturating 2-bit counter step; explicit end checks so it never wraps.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (cnt == 2'b11) res = 2'b11;
      else              res = cnt + 2'b01;
    end else begin
      if (cnt == 2'b00) res = 2'b00;
      else              res = cnt - 2'b01;
    end
    return res;
  endfunction

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic                   ready_q, ready_d;
  logic                   pred_valid_q, pred_valid_d;
  logic                   pred_taken_q, pred_taken_d;
  logic [1:0]             pred_counter_q, pred_counter_d;

  logic [1:0]             table_q [ENTRIES];

  logic                   wr_en_s;
  logic [INDEX_WIDTH-1:0] wr_idx_s;
  logic [1:0]             wr_val_s;
  logic [INDEX_WIDTH-1:0] lookup_idx_s;
  logic [1:0]             upd_next_s;
  logic [1:0]             lookup_cnt_s;
  logic                   unused_pc_s;

  // Upper and byte-offset PC bits do not take part in indexing (aliasing allowed).
  assign lookup_idx_s = bht_if.lookup_pc_in[INDEX_WIDTH+1:2];
  assign unused_pc_s  = ^{bht_if.lookup_pc_in[31:INDEX_WIDTH+2], bht_if.lookup_pc_in[1:0]};

  // Trained counter value and lookup result with same-index update bypass.
  always_comb begin
    upd_next_s   = sat_next(table_q[bht_if.update_indx_in], bht_if.update_taken_in);
    lookup_cnt_s = table_q[lookup_idx_s];
    if (bht_if.update_enable_in && (bht_if.update_indx_in == lookup_idx_s)) begin
      lookup_cnt_s = upd_next_s;
    end else begin
      lookup_cnt_s = table_q[lookup_idx_s];
    end
  end

  // Next-state, table write port and registered-output next values.
  always_comb begin
    state_d        = state_q;
    init_ptr_d     = init_ptr_q;
    ready_d        = ready_q;
    pred_valid_d   = pred_valid_q;
    pred_taken_d   = pred_taken_q;
    pred_counter_d = pred_counter_q;
    wr_en_s        = 1'b0;
    wr_idx_s       = '0;
    wr_val_s       = 2'b00;

    case (state_q)
      INIT: begin
        wr_en_s      = 1'b1;
        wr_idx_s     = init_ptr_q;
        wr_val_s     = INIT_STATE;
        init_ptr_d   = init_ptr_q + PTR_ONE;
        pred_valid_d = 1'b0;
        // Lookups and updates are ignored until every entry is written.
        if (init_ptr_q == PTR_LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          state_d = INIT;
          ready_d = 1'b0;
        end
      end

      RUN: begin
        state_d      = RUN;
        ready_d      = 1'b1;
        pred_valid_d = bht_if.lookup_valid_in;
        // Without a valid lookup the previous prediction is held.
        if (bht_if.lookup_valid_in) begin
          pred_counter_d = lookup_cnt_s;
          pred_taken_d   = lookup_cnt_s[1];
        end else begin
          pred_counter_d = pred_counter_q;
          pred_taken_d   = pred_taken_q;
        end
        if (bht_if.update_enable_in) begin
          wr_en_s  = 1'b1;
          wr_idx_s = bht_if.update_indx_in;
          wr_val_s = upd_next_s;
        end else begin
          wr_en_s  = 1'b0;
        end
      end

      default: begin
        state_d      = INIT;
        init_ptr_d   = '0;
        ready_d      = 1'b0;
        pred_valid_d = 1'b0;
      end
    endcase
  end

  // State, init pointer and output registers with asynchronous reset.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q        <= INIT;
      init_ptr_q     <= '0;
      ready_q        <= 1'b0;
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_counter_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      init_ptr_q     <= init_ptr_d;
      ready_q        <= ready_d;
      pred_valid_q   <= pred_valid_d;
      pred_taken_q   <= pred_taken_d;
      pred_counter_q <= pred_counter_d;
    end
  end

  // Counter storage; contents are defined by the init walk, not by reset.
  always_ff @(posedge clock_in) begin
    if (wr_en_s) begin
      table_q[wr_idx_s] <= wr_val_s;
    end
  end

  assign bht_if.ready_out        = ready_q;
  assign bht_if.pred_valid_out   = pred_valid_q;
  assign bht_if.pred_taken_out   = pred_taken_q;
  assign bht_if.pred_counter_out = pred_counter_q;

endmodule

// File: tb/tb_ifu_branch_history_table.sv
// ---------------------------------------------------------------------------
// tb_ifu_branch_history_table
//   Self-checking bench for ifu_branch_history_table: init timing, fixed
//   vector table for saturation/bypass/aliasing, randomized traffic against
//   an array-based counter model, and asynchronous reset during init.
// ---------------------------------------------------------------------------
module tb_ifu_branch_history_table;

  localparam int IW      = 10;
  localparam int ENTRIES = 1 << IW;

  logic clk;
  logic rst;

  ifu_branch_history_table_if #(.INDEX_WIDTH(IW)) bht_if ();

  ifu_branch_history_table #(
    .INDEX_WIDTH (IW),
    .INIT_STATE  (2'b01)
  ) dut (
    .clock_in (clk),
    .reset_in (rst),
    .bht_if   (bht_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: plain integer counter per entry.
  int model [ENTRIES];
  int exp_v;
  int exp_c;
  int exp_t;

  typedef struct {
    bit          lv;
    logic [31:0] pc;
    bit          ue;
    logic [9:0]  ui;
    bit          ut;
    bit          ev;
    logic [1:0]  ec;
    bit          et;
  } vec_t;

  vec_t vecs [17];

  function automatic int sat(input int c, input bit t);
    if (t) return (c < 3) ? c + 1 : 3;
    else   return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_init();
    for (int i = 0; i < ENTRIES; i++) model[i] = 1;
    exp_v = 0;
    exp_c = 0;
    exp_t = 0;
  endtask

  // Called at a negedge: drive one cycle of stimulus, advance the model,
  // return at the following negedge ready for sampling.
  task automatic step(input bit lv, input logic [31:0] pc, input bit ue,
                      input logic [9:0] ui, input bit ut);
    int li;
    int prior;
    bht_if.lookup_valid_in  = lv;
    bht_if.lookup_pc_in     = pc;
    bht_if.update_enable_in = ue;
    bht_if.update_indx_in   = ui;
    bht_if.update_taken_in  = ut;
    li    = int'((pc >> 2) & 32'h3FF);
    exp_v = lv ? 1 : 0;
    if (lv) begin
      prior = model[li];
      if (ue && (int'(ui) == li)) exp_c = sat(prior, ut);
      else                        exp_c = prior;
      exp_t = (exp_c >= 2) ? 1 : 0;
    end
    if (ue) model[ui] = sat(model[ui], ut);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bht_if.lookup_valid_in  = 1'b0;
    bht_if.lookup_pc_in     = 32'h0;
    bht_if.update_enable_in = 1'b0;
    bht_if.update_indx_in   = 10'h0;
    bht_if.update_taken_in  = 1'b0;
  endtask

  // Count clocks until ready_out, with lookups/updates active to prove they are ignored.
  task automatic wait_ready(output int cycles, output int bad_valid);
    cycles    = 0;
    bad_valid = 0;
    while (bht_if.ready_out !== 1'b1 && cycles < 1100) begin
      bht_if.lookup_valid_in  = 1'b1;
      bht_if.lookup_pc_in     = 32'h0000_0000;
      bht_if.update_enable_in = (cycles > 4) ? 1'b1 : 1'b0;
      bht_if.update_indx_in   = (cycles % 2 == 0) ? 10'h000 : 10'h007;
      bht_if.update_taken_in  = 1'b1;
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (bht_if.pred_valid_out !== 1'b0) bad_valid++;
    end
    idle_inputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   32'(bht_if.ready_out),        32'h0);
    check({tag, "_valid"},   32'(bht_if.pred_valid_out),   32'h0);
    check({tag, "_taken"},   32'(bht_if.pred_taken_out),   32'h0);
    check({tag, "_counter"}, 32'(bht_if.pred_counter_out), 32'h0);
  endtask

  task automatic readback_all(input string tag);
    for (int i = 0; i < ENTRIES; i++) begin
      step(1'b1, 32'(i) << 2, 1'b0, 10'h0, 1'b0);
      check(tag, 32'(bht_if.pred_counter_out), 32'(exp_c));
    end
  endtask

  initial begin
    int cycles;
    int bad_valid;
    bit          lv, ue, ut;
    logic [31:0] pc;
    logic [9:0]  ui;

    // Fixed vectors: saturation, bypass, independence, aliasing.
    vecs[0]  = '{1'b1, 32'h0000_0040, 1'b0, 10'h000, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 1'b1, 10'h010, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0000, 1'b1, 10'h010, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0000, 1'b1, 10'h010, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0040, 1'b0, 10'h000, 1'b0, 1'b1, 2'b11, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_1040, 1'b1, 10'h010, 1'b1, 1'b1, 2'b11, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 1'b1, 10'h010, 1'b0, 1'b0, 2'b11, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 1'b1, 10'h010, 1'b0, 1'b0, 2'b11, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 1'b1, 10'h010, 1'b0, 1'b0, 2'b11, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 1'b1, 10'h010, 1'b0, 1'b0, 2'b11, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0040, 1'b1, 10'h010, 1'b0, 1'b1, 2'b00, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0000, 1'b1, 10'h010, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0040, 1'b1, 10'h010, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[13] = '{1'b1, 32'h0000_0040, 1'b1, 10'h011, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[14] = '{1'b1, 32'h0000_0044, 1'b0, 10'h000, 1'b0, 1'b1, 2'b10, 1'b1};
    vecs[15] = '{1'b1, 32'hFFFF_F040, 1'b0, 10'h000, 1'b0, 1'b1, 2'b10, 1'b1};
    vecs[16] = '{1'b1, 32'h0000_0043, 1'b0, 10'h000, 1'b0, 1'b1, 2'b10, 1'b1};

    idle_inputs();
    model_init();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Init length and pred_valid suppression.
    rst = 1'b0;
    wait_ready(cycles, bad_valid);
    check("init_cycles", 32'(cycles), 32'd1024);
    check("init_valid_low", 32'(bad_valid), 32'd0);
    check("ready_high", 32'(bht_if.ready_out), 32'h1);
    readback_all("init_readback");

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].lv, vecs[i].pc, vecs[i].ue, vecs[i].ui, vecs[i].ut);
      check($sformatf("vec%0d_valid", i),   32'(bht_if.pred_valid_out),   32'(vecs[i].ev));
      check($sformatf("vec%0d_counter", i), 32'(bht_if.pred_counter_out), 32'(vecs[i].ec));
      check($sformatf("vec%0d_taken", i),   32'(bht_if.pred_taken_out),   32'(vecs[i].et));
    end

    // Randomized traffic concentrated on a few entries to force collisions.
    for (int n = 0; n < 1500; n++) begin
      lv = 1'($urandom_range(0, 1));
      ue = 1'($urandom_range(0, 1));
      ut = 1'($urandom_range(0, 1));
      ui = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(16, 23));
      pc = $urandom;
      if ($urandom_range(0, 1) == 1) pc[11:2] = ui;
      else                            pc[11:2] = 10'($urandom_range(16, 23));
      step(lv, pc, ue, ui, ut);
      check("rand_valid",   32'(bht_if.pred_valid_out),   32'(exp_v));
      check("rand_counter", 32'(bht_if.pred_counter_out), 32'(exp_c));
      check("rand_taken",   32'(bht_if.pred_taken_out),   32'(exp_t));
    end

    // Async reset from RUN with non-zero held outputs.
    step(1'b0, 32'h0, 1'b1, 10'h011, 1'b1);
    step(1'b0, 32'h0, 1'b1, 10'h011, 1'b1);
    step(1'b1, 32'h0000_0044, 1'b0, 10'h000, 1'b0);
    check("pre_reset_counter", 32'(bht_if.pred_counter_out), 32'(exp_c));
    check("pre_reset_taken",   32'(bht_if.pred_taken_out),   32'h1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_run");
    @(negedge clk);
    rst = 1'b0;

    // Partial init, then reset at init_ptr=500.
    for (int k = 0; k < 500; k++) begin
      bht_if.lookup_valid_in  = 1'b1;
      bht_if.update_enable_in = 1'b1;
      bht_if.update_indx_in   = 10'h000;
      bht_if.update_taken_in  = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_init");
    @(negedge clk);
    rst = 1'b0;
    wait_ready(cycles, bad_valid);
    check("reinit_cycles", 32'(cycles), 32'd1024);
    check("reinit_valid_low", 32'(bad_valid), 32'd0);
    model_init();
    readback_all("reinit_readback");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
